// File: rtl/sfifo_rr_arbiter.sv
// rtl/sfifo_rr_arbiter.sv - round-robin burst arbiter sharing one sfifo write port among COUNT producers
//
// Ports:
//   clock, reset       rising-edge clock, asynchronous active-low reset
//   receiver_data      COUNT packed producer beats, slice i = [i*WIDTH +: WIDTH]
//   receiver_valid     per-producer valid
//   receiver_ready     per-producer ready, one-hot or zero
//   sender_data        registered output beat
//   sender_valid       registered output valid
//   sender_index       producer that owns the current output beat
//   sender_ready       downstream sfifo ready
module sfifo_rr_arbiter #(
    parameter int WIDTH     = 32,
    parameter int COUNT     = 4,
    parameter int MAX_BURST = 4,
    parameter int IDX_W     = $clog2(COUNT)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [COUNT*WIDTH-1:0]   receiver_data,
    input  logic [COUNT-1:0]         receiver_valid,
    output logic [COUNT-1:0]         receiver_ready,
    output logic [WIDTH-1:0]         sender_data,
    output logic                     sender_valid,
    output logic [IDX_W-1:0]         sender_index,
    input  logic                     sender_ready
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);
    localparam logic [IDX_W:0]   COUNT_X   = (IDX_W + 1)'(COUNT);

    logic [WIDTH-1:0] sender_data_q,  sender_data_d;
    logic             sender_valid_q, sender_valid_d;
    logic [IDX_W-1:0] sender_index_q, sender_index_d;
    logic [IDX_W-1:0] owner_q,        owner_d;
    logic [CNT_W-1:0] burst_cnt_q,    burst_cnt_d;
    logic [IDX_W-1:0] last_ptr_q,     last_ptr_d;

    logic             any_valid;
    logic             load_en;
    logic             hold;
    logic             rr_found;
    logic [IDX_W-1:0] rr_sel;
    logic [IDX_W:0]   scan_idx;
    logic [IDX_W-1:0] sel;

    assign any_valid = |receiver_valid;
    assign load_en   = !sender_valid_q || sender_ready;

    // Owner keeps the grant only while it stays valid inside an open burst.
    assign hold = receiver_valid[owner_q] && (burst_cnt_q != '0) && (burst_cnt_q < BURST_MAX);

    // Scan starts just after the last winner and wraps; the last winner
    // itself is visited last, which re-grants a lone producer without a bubble.
    always_comb begin
        rr_found = 1'b0;
        rr_sel   = last_ptr_q;
        scan_idx = '0;
        for (int k = 1; k <= COUNT; k++) begin
            scan_idx = {1'b0, last_ptr_q} + (IDX_W + 1)'(k);
            if (scan_idx >= COUNT_X) begin
                scan_idx = scan_idx - COUNT_X;
            end
            if (!rr_found && receiver_valid[scan_idx[IDX_W-1:0]]) begin
                rr_found = 1'b1;
                rr_sel   = scan_idx[IDX_W-1:0];
            end
        end
    end

    assign sel = hold ? owner_q : rr_sel;

    // Ready is forced low during reset so producers keep their beats.
    always_comb begin
        receiver_ready = '0;
        for (int i = 0; i < COUNT; i++) begin
            receiver_ready[i] = reset && load_en && any_valid && (sel == IDX_W'(i));
        end
    end

    always_comb begin
        sender_data_d  = sender_data_q;
        sender_valid_d = sender_valid_q;
        sender_index_d = sender_index_q;
        owner_d        = owner_q;
        burst_cnt_d    = burst_cnt_q;
        last_ptr_d     = last_ptr_q;
        if (load_en) begin
            if (any_valid) begin
                sender_data_d  = receiver_data[int'(sel)*WIDTH +: WIDTH];
                sender_valid_d = 1'b1;
                sender_index_d = sel;
                last_ptr_d     = sel;
                owner_d        = sel;
                if ((sel == owner_q) && (burst_cnt_q < BURST_MAX)) begin
                    burst_cnt_d = burst_cnt_q + 1'b1;
                end else begin
                    burst_cnt_d = CNT_W'(1);
                end
            end else begin
                // Idle cycle releases the grant; data/index keep last beat.
                sender_valid_d = 1'b0;
                burst_cnt_d    = '0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sender_data_q  <= '0;
            sender_valid_q <= 1'b0;
            sender_index_q <= '0;
            owner_q        <= '0;
            burst_cnt_q    <= '0;
            last_ptr_q     <= IDX_W'(COUNT - 1);
        end else begin
            sender_data_q  <= sender_data_d;
            sender_valid_q <= sender_valid_d;
            sender_index_q <= sender_index_d;
            owner_q        <= owner_d;
            burst_cnt_q    <= burst_cnt_d;
            last_ptr_q     <= last_ptr_d;
        end
    end

    assign sender_data  = sender_data_q;
    assign sender_valid = sender_valid_q;
    assign sender_index = sender_index_q;

endmodule

// File: tb/tb_sfifo_rr_arbiter.sv
// tb/tb_sfifo_rr_arbiter.sv - directed and scoreboard bench for sfifo_rr_arbiter
module tb_sfifo_rr_arbiter;

    localparam int W  = 32;
    localparam int C  = 4;
    localparam int MB = 4;

    logic           clock = 1'b0;
    logic           reset = 1'b0;
    logic [C*W-1:0] receiver_data;
    logic [C-1:0]   receiver_valid;
    logic [C-1:0]   receiver_ready;
    logic [W-1:0]   sender_data;
    logic           sender_valid;
    logic [1:0]     sender_index;
    logic           sender_ready;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] base [C];
    int           seq  [C];
    int           out_seq [C];
    int           wait_cnt [C];

    logic [C-1:0] rdy_s;
    logic [C-1:0] vld_s;
    logic         oxfer;
    logic [1:0]   oidx;
    logic [W-1:0] odata;

    sfifo_rr_arbiter #(.WIDTH(W), .COUNT(C), .MAX_BURST(MB)) dut (
        .clock          (clock),
        .reset          (reset),
        .receiver_data  (receiver_data),
        .receiver_valid (receiver_valid),
        .receiver_ready (receiver_ready),
        .sender_data    (sender_data),
        .sender_valid   (sender_valid),
        .sender_index   (sender_index),
        .sender_ready   (sender_ready)
    );

    always #5 clock = ~clock;

    task automatic drive();
        for (int i = 0; i < C; i++) receiver_data[i*W +: W] = base[i] + W'(seq[i]);
    endtask

    // Sample handshakes at the falling edge, then advance past the rising edge.
    task automatic step();
        @(negedge clock);
        rdy_s = receiver_ready;
        vld_s = receiver_valid;
        oxfer = sender_valid && sender_ready;
        oidx  = sender_index;
        odata = sender_data;
        @(posedge clock);
        #1;
        for (int i = 0; i < C; i++) if (rdy_s[i]) seq[i]++;
        drive();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        receiver_valid = '0;
        sender_ready = 1'b1;
        for (int i = 0; i < C; i++) begin
            seq[i] = 0;
            base[i] = W'(i) << 8;
        end
        drive();
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    task automatic check_beat(input string name, input int k, input int e_idx, input logic [W-1:0] e_data);
        checks++;
        if (sender_valid !== 1'b1 || sender_index !== 2'(e_idx) || sender_data !== e_data) begin
            errors++;
            $display("FAIL %s beat %0d: got v=%0b idx=%0d data=%h, expected v=1 idx=%0d data=%h",
                     name, k, sender_valid, sender_index, sender_data, e_idx, e_data);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        sender_ready = 1'b1;
        receiver_valid = '1;
        for (int i = 0; i < C; i++) begin seq[i] = 0; base[i] = 32'h55; end
        drive();
        #3;
        checks++;
        if (sender_valid !== 1'b0 || sender_data !== '0 || sender_index !== 2'd0 || receiver_ready !== 4'b0) begin
            errors++;
            $display("FAIL reset_state: v=%0b data=%h idx=%0d ready=%b, expected 0/0/0/0000",
                     sender_valid, sender_data, sender_index, receiver_ready);
        end
    endtask

    task automatic test_round_robin();
        int exp_idx [17] = '{0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0};
        logic [W-1:0] ed;
        do_reset();
        receiver_valid = 4'b1111;
        for (int k = 0; k < 17; k++) begin
            ed = base[exp_idx[k]] + W'(seq[exp_idx[k]]);
            step();
            check_beat("round_robin", k, exp_idx[k], ed);
        end
    endtask

    task automatic test_single_burst();
        do_reset();
        base[2] = 32'h100;
        drive();
        receiver_valid = 4'b0100;
        for (int k = 0; k < 10; k++) begin
            step();
            check_beat("single_burst", k, 2, 32'h100 + W'(k));
        end
    endtask

    task automatic test_release();
        int exp_idx [7] = '{1,1,3,3,3,3,1};
        logic [3:0] vl [7] = '{4'b1010, 4'b1010, 4'b1000, 4'b1010, 4'b1010, 4'b1010, 4'b1010};
        logic [W-1:0] ed;
        do_reset();
        for (int k = 0; k < 7; k++) begin
            receiver_valid = vl[k];
            ed = base[exp_idx[k]] + W'(seq[exp_idx[k]]);
            step();
            check_beat("release", k, exp_idx[k], ed);
        end
    endtask

    task automatic test_stall();
        do_reset();
        base[0] = 32'hA5;
        drive();
        receiver_valid = 4'b0001;
        step();
        check_beat("stall_first", 0, 0, 32'hA5);
        sender_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            check_beat("stall_hold", k, 0, 32'hA5);
            checks++;
            if (rdy_s !== 4'b0000) begin
                errors++;
                $display("FAIL stall_ready cycle %0d: got %b expected 0000", k, rdy_s);
            end
        end
        sender_ready = 1'b1;
        step();
        checks++;
        if (rdy_s !== 4'b0001) begin
            errors++;
            $display("FAIL stall_resume_ready: got %b expected 0001", rdy_s);
        end
        check_beat("stall_resume", 0, 0, 32'hA6);
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        base[1] = 32'h1000;
        drive();
        receiver_valid = 4'b0010;
        step();
        step();
        check_beat("pre_reset", 1, 1, 32'h1001);
        receiver_valid = 4'b1111;
        @(negedge clock);
        #1;
        reset = 1'b0;
        #1;
        checks++;
        if (sender_valid !== 1'b0 || receiver_ready !== 4'b0000) begin
            errors++;
            $display("FAIL async_reset: v=%0b ready=%b expected 0/0000", sender_valid, receiver_ready);
        end
        @(posedge clock);
        #1;
        checks++;
        if (sender_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_held: v=%0b expected 0", sender_valid);
        end
        reset = 1'b1;
        step();
        check_beat("after_reset", 0, 0, base[0] + W'(seq[0] - 1));
    endtask

    task automatic test_random();
        int maxw = 0;
        do_reset();
        for (int i = 0; i < C; i++) begin
            base[i] = W'(i) << 16;
            out_seq[i] = 0;
            wait_cnt[i] = 0;
        end
        drive();
        for (int cyc = 0; cyc < 2000; cyc++) begin
            for (int i = 0; i < C; i++) receiver_valid[i] = ($urandom_range(0, 3) != 0);
            sender_ready = ($urandom_range(0, 3) != 0);
            step();
            if (oxfer) begin
                checks++;
                if (odata !== base[oidx] + W'(out_seq[oidx])) begin
                    errors++;
                    $display("FAIL random_order cycle %0d idx %0d: got %h expected %h",
                             cyc, oidx, odata, base[oidx] + W'(out_seq[oidx]));
                end
                out_seq[oidx]++;
            end
            for (int i = 0; i < C; i++) begin
                if (rdy_s[i] || !vld_s[i]) wait_cnt[i] = 0;
                else if (|rdy_s) wait_cnt[i]++;
                if (wait_cnt[i] > maxw) maxw = wait_cnt[i];
            end
        end
        checks++;
        if (maxw > 3 * MB) begin
            errors++;
            $display("FAIL random_fairness: max wait %0d beats, limit %0d", maxw, 3 * MB);
        end
        receiver_valid = '0;
        sender_ready = 1'b1;
        repeat (3) begin
            step();
            if (oxfer) begin
                checks++;
                if (odata !== base[oidx] + W'(out_seq[oidx])) begin
                    errors++;
                    $display("FAIL drain_order idx %0d: got %h expected %h",
                             oidx, odata, base[oidx] + W'(out_seq[oidx]));
                end
                out_seq[oidx]++;
            end
        end
        for (int i = 0; i < C; i++) begin
            checks++;
            if (out_seq[i] != seq[i]) begin
                errors++;
                $display("FAIL random_count producer %0d: sent %0d accepted %0d", i, out_seq[i], seq[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single_burst();
        test_release();
        test_stall();
        test_reset_mid_burst();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
